ddr_dq_sequencer: RTL and testbench
===================================

Name: ddr_dq_sequencer

Overview:
- Bus-side burst sequencer that drives and collects the PCLK-rate D0/D1/OEN/Q0/Q1 pins of a lane of gw2a DDR IOBs.
- Writes: accepts a command, waits a fixed write latency, then frames the data burst with OEN preamble and postamble.
- Reads: counts the read latency, captures Q0/Q1 and returns them as a valid-only stream.
- Sits between the DDR controller's command/data datapath and the IOB array.

Parameters:
- WIDTH, 16, number of DQ IOBs driven; bus data is 2*WIDTH.
- WR_LAT, 2, PCLK cycles from command accept to first driven (preamble) cycle, minus one; legal range 1..15.
- RD_LAT, 6, PCLK cycles from command accept to first Q sample; legal range 1..31.
- PREAMBLE, 1, cycles of OEN active with D=0 before the first beat; legal range 0..3.
- POSTAMBLE, 1, cycles of OEN active with D=0 after the last beat; legal range 0..3.
- TURN, 2, idle cycles forced between the end of a write and acceptance of a read; legal range 0..7.

Ports:
- PCLK  in  1  bus clock, the same PCLK fed to the IOBs.
- RESET  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accept.
- cmd_write_i  in  1  1 = write burst, 0 = read burst.
- cmd_len_i  in  4  beats minus one (1..16 beats).
- wr_valid_i  in  1  write data valid.
- wr_ready_o  out  1  write data consumed this cycle.
- wr_data_i  in  2*WIDTH  [W-1:0] goes to D0, [2W-1:W] goes to D1.
- rd_valid_o  out  1  read beat valid; no backpressure.
- rd_last_o  out  1  final beat of the read burst.
- rd_data_o  out  2*WIDTH  {Q1,Q0} sample.
- err_underrun_o  out  1  sticky; set if a write beat is consumed while wr_valid_i=0.
- phy_oen_o  out  WIDTH  IOB OEN, all bits equal; 1 = tristate.
- phy_d0_o  out  WIDTH  IOB D0.
- phy_d1_o  out  WIDTH  IOB D1.
- phy_q0_i  in  WIDTH  IOB Q0.
- phy_q1_i  in  WIDTH  IOB Q1.

Behaviour:
- Reset values: phy_oen_o all ones; phy_d0_o, phy_d1_o = 0; rd_valid_o = 0; rd_last_o = 0; rd_data_o = 0; wr_ready_o = 0; err_underrun_o = 0; cmd_ready_o = 0 while RESET is asserted; state IDLE; turn counter = 0.
- Reset asserted mid-burst aborts the burst immediately. No partial beats follow. The bus is tristated asynchronously.
- All phy_* and rd_* outputs are registered.
- FSM states: IDLE, WLAT, WPRE, WDATA, WPOST, RLAT, RDATA.
- cmd_ready_o = 1 in IDLE, except when a read is presented while the turn counter is nonzero.
  - Writes are accepted in IDLE regardless of the turn counter.
- Accept cycle A: cmd_valid_i & cmd_ready_o. cmd_len_i is latched at A.
- Write accept → WLAT. Let T = A + WR_LAT + 1, the first cycle the pins change.
  - Preamble: cycles T .. T+PREAMBLE-1 have phy_oen_o = 0 and D = 0.
  - Beat k (k = 0..len): appears on phy_d0_o/phy_d1_o at cycle T+PREAMBLE+k, with phy_oen_o = 0.
  - wr_ready_o = 1 in cycles T+PREAMBLE-1+k, one cycle ahead of each pin beat. Exactly len+1 ready pulses.
  - wr_valid_i = 0 at a ready cycle: that beat is driven as 0, err_underrun_o sets, and the burst still advances. Underrun never stalls the burst.
  - Postamble: the POSTAMBLE cycles after the last beat have phy_oen_o = 0 and D = 0. The next cycle has phy_oen_o = 1 and D = 0.
  - On return to IDLE the turn counter loads TURN and then decrements each cycle to 0.
- Read accept → RLAT. Let S = A + RD_LAT.
  - phy_q0_i/phy_q1_i are sampled at cycles S .. S+len.
  - Each sample appears on rd_data_o with rd_valid_o = 1 one cycle later (S+1+k).
  - rd_last_o = 1 only with beat len.
  - phy_oen_o stays 1 for the whole read.
  - The FSM returns to IDLE in cycle S+len+1. Back-to-back reads are then allowed with no gap.
- Zero-length phases: PREAMBLE = 0 or POSTAMBLE = 0 skips the corresponding state.
- Counters: 5-bit latency counter, 4-bit beat counter, 3-bit turn counter. There is no wrap beyond len.
- While not in IDLE, cmd_valid_i is ignored (cmd_ready_o = 0).
- err_underrun_o is cleared only by RESET.

Test Plan:
- Defaults, write with len = 3, data 0x0001_0002, 0x0003_0004, 0x0005_0006, 0x0007_0008, accepted at cycle 10 → wr_ready_o high at cycles 13..16; phy_oen_o = 0 at cycles 13..18; D = 0 at 13 and 18; beats on D at cycles 14..17; phy_oen_o = 1 at cycle 19.
- Defaults, read with len = 1 accepted at cycle 10, Q driven with 0xAAAA/0x5555 at cycle 16 and 0x1234/0x5678 at cycle 17 → rd_valid_o at cycles 17..18; rd_data_o = 0x5555_AAAA, then 0x5678_1234; rd_last_o only at cycle 18; phy_oen_o = 1 throughout.
- Write followed immediately by a pending read → the read is accepted no earlier than 2 cycles after the write returns to IDLE; a pending write in the same situation is accepted on the first IDLE cycle.
- wr_valid_i held low on beat 2 of a len = 3 write → beat 2 is driven as 0, err_underrun_o = 1 from then until RESET, and the burst still ends on schedule.
- RESET pulsed during WDATA beat 1 → phy_oen_o = all ones and D = 0 immediately; no further wr_ready_o; after release, cmd_ready_o = 1 and a new write runs correctly.
- PREAMBLE = 0, POSTAMBLE = 0, len = 0 write → phy_oen_o = 0 for exactly one cycle, carrying the beat.

Source files
------------

// File: rtl/ddr_dq_sequencer_if.sv
// Bus-side channels of the DQ burst sequencer: command,
// write data (ready-paced) and read data (valid-only).
interface ddr_dq_sequencer_if #(
   parameter int WIDTH = 16
);
   logic               cmd_valid_i;
   logic               cmd_ready_o;
   logic               cmd_write_i;
   logic [3:0]         cmd_len_i;
   logic               wr_valid_i;
   logic               wr_ready_o;
   logic [2*WIDTH-1:0] wr_data_i;
   logic               rd_valid_o;
   logic               rd_last_o;
   logic [2*WIDTH-1:0] rd_data_o;
   logic               err_underrun_o;

   modport master (
      output cmd_valid_i, cmd_write_i, cmd_len_i,
      output wr_valid_i, wr_data_i,
      input  cmd_ready_o, wr_ready_o,
      input  rd_valid_o, rd_last_o, rd_data_o,
      input  err_underrun_o
   );

   modport slave (
      input  cmd_valid_i, cmd_write_i, cmd_len_i,
      input  wr_valid_i, wr_data_i,
      output cmd_ready_o, wr_ready_o,
      output rd_valid_o, rd_last_o, rd_data_o,
      output err_underrun_o
   );
endinterface

// File: rtl/ddr_dq_sequencer.sv
// Burst sequencer for one lane of PCLK-rate DDR IOBs: frames write
// bursts with OEN pre/postamble and collects read beats after latency.
module ddr_dq_sequencer #(
   parameter int WIDTH     = 16,
   parameter int WR_LAT    = 2,
   parameter int RD_LAT    = 6,
   parameter int PREAMBLE  = 1,
   parameter int POSTAMBLE = 1,
   parameter int TURN      = 2
) (
   input  logic             PCLK,
   input  logic             RESET,
   ddr_dq_sequencer_if.slave bus,
   output logic [WIDTH-1:0] phy_oen_o,
   output logic [WIDTH-1:0] phy_d0_o,
   output logic [WIDTH-1:0] phy_d1_o,
   input  logic [WIDTH-1:0] phy_q0_i,
   input  logic [WIDTH-1:0] phy_q1_i
);
   typedef enum logic [2:0] {
      IDLE, WLAT, WPRE, WDATA, WPOST, RLAT, RDATA
   } state_e;

   state_e             state_q, state_d;
   logic [4:0]         lat_q, lat_d;
   logic [3:0]         beat_q, beat_d;
   logic [3:0]         len_q, len_d;
   logic [2:0]         turn_q, turn_d;
   logic               err_q;
   logic               oen_q;
   logic [WIDTH-1:0]   d0_q, d1_q;
   logic               rd_valid_q, rd_last_q;
   logic [2*WIDTH-1:0] rd_data_q;
   logic               rd_block, accept, take, wdrive, rsample;

   // Reads wait out the bus turnaround; writes never do.
   assign rd_block = bus.cmd_valid_i & ~bus.cmd_write_i
                   & (turn_q != 3'd0);
   assign bus.cmd_ready_o = (state_q == IDLE) & ~rd_block & ~RESET;
   assign accept = bus.cmd_valid_i & bus.cmd_ready_o;

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      beat_d  = beat_q;
      len_d   = len_q;
      turn_d  = (turn_q != 3'd0) ? turn_q - 3'd1 : turn_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               len_d  = bus.cmd_len_i;
               beat_d = 4'd0;
               if (bus.cmd_write_i) begin
                  state_d = WLAT;
                  lat_d   = 5'(WR_LAT - 1);
               end else if (RD_LAT > 1) begin
                  state_d = RLAT;
                  lat_d   = 5'(RD_LAT - 2);
               end else begin
                  state_d = RDATA;
               end
            end
         end
         WLAT: begin
            if (lat_q != 5'd0) begin
               lat_d = lat_q - 5'd1;
            end else if (PREAMBLE > 0) begin
               state_d = WPRE;
               lat_d   = 5'(PREAMBLE - 1);
            end else begin
               state_d = WDATA;
            end
         end
         WPRE: begin
            if (lat_q != 5'd0) lat_d = lat_q - 5'd1;
            else               state_d = WDATA;
         end
         WDATA: begin
            if (beat_q != len_q) begin
               beat_d = beat_q + 4'd1;
            end else if (POSTAMBLE > 0) begin
               state_d = WPOST;
               lat_d   = 5'(POSTAMBLE - 1);
            end else begin
               state_d = IDLE;
               turn_d  = 3'(TURN);
            end
         end
         WPOST: begin
            if (lat_q != 5'd0) begin
               lat_d = lat_q - 5'd1;
            end else begin
               state_d = IDLE;
               turn_d  = 3'(TURN);
            end
         end
         RLAT: begin
            if (lat_q != 5'd0) lat_d = lat_q - 5'd1;
            else               state_d = RDATA;
         end
         RDATA: begin
            if (beat_q != len_q) beat_d = beat_q + 4'd1;
            else                 state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pins are loaded from the next state, so a beat is taken one cycle
   // before it shows on D.
   assign take    = (state_d == WDATA);
   assign wdrive  = (state_d == WPRE) | take | (state_d == WPOST);
   assign rsample = (state_q == RDATA);

   always_ff @(posedge PCLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= IDLE;
         lat_q      <= 5'd0;
         beat_q     <= 4'd0;
         len_q      <= 4'd0;
         turn_q     <= 3'd0;
         err_q      <= 1'b0;
         oen_q      <= 1'b1;
         d0_q       <= '0;
         d1_q       <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         lat_q      <= lat_d;
         beat_q     <= beat_d;
         len_q      <= len_d;
         turn_q     <= turn_d;
         err_q      <= err_q | (take & ~bus.wr_valid_i);
         oen_q      <= ~wdrive;
         d0_q       <= (take & bus.wr_valid_i)
                     ? bus.wr_data_i[WIDTH-1:0] : '0;
         d1_q       <= (take & bus.wr_valid_i)
                     ? bus.wr_data_i[2*WIDTH-1:WIDTH] : '0;
         rd_valid_q <= rsample;
         rd_last_q  <= rsample & (beat_q == len_q);
         if (rsample) rd_data_q <= {phy_q1_i, phy_q0_i};
      end
   end

   assign bus.wr_ready_o     = take;
   assign bus.err_underrun_o = err_q;
   assign bus.rd_valid_o     = rd_valid_q;
   assign bus.rd_last_o      = rd_last_q;
   assign bus.rd_data_o      = rd_data_q;
   assign phy_oen_o          = {WIDTH{oen_q}};
   assign phy_d0_o           = d0_q;
   assign phy_d1_o           = d1_q;
endmodule

// File: tb/tb_ddr_dq_sequencer.sv
// Randomized bench for ddr_dq_sequencer: every cycle of every burst is
// compared with a timing model built from accept-cycle arithmetic.
module tb_ddr_dq_sequencer;
   localparam int W      = 16;
   localparam int WR_LAT = 2;
   localparam int RD_LAT = 6;
   localparam int PRE    = 1;
   localparam int POST   = 1;
   localparam int TURN   = 2;
   localparam int Z_WR_LAT = 3;

   typedef logic [2*W-1:0] word_t;
   typedef logic [W-1:0]   half_t;

   logic  PCLK = 1'b0;
   logic  RESET = 1'b1;
   half_t q0, q1;
   half_t oen, d0, d1;
   half_t z_oen, z_d0, z_d1;
   int    cyc = 0;
   int    vectors = 0;
   int    miscompares = 0;
   bit    err_exp = 1'b0;
   int    turn_free = 0;
   word_t q_hist [int];

   ddr_dq_sequencer_if #(.WIDTH(W)) bus ();
   ddr_dq_sequencer_if #(.WIDTH(W)) bus2 ();

   ddr_dq_sequencer #(
      .WIDTH(W), .WR_LAT(WR_LAT), .RD_LAT(RD_LAT),
      .PREAMBLE(PRE), .POSTAMBLE(POST), .TURN(TURN)
   ) dut (
      .PCLK(PCLK), .RESET(RESET), .bus(bus),
      .phy_oen_o(oen), .phy_d0_o(d0), .phy_d1_o(d1),
      .phy_q0_i(q0), .phy_q1_i(q1)
   );

   ddr_dq_sequencer #(
      .WIDTH(W), .WR_LAT(Z_WR_LAT), .RD_LAT(1),
      .PREAMBLE(0), .POSTAMBLE(0), .TURN(0)
   ) dut_z (
      .PCLK(PCLK), .RESET(RESET), .bus(bus2),
      .phy_oen_o(z_oen), .phy_d0_o(z_d0), .phy_d1_o(z_d1),
      .phy_q0_i(q0), .phy_q1_i(q1)
   );

   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   // Pin-side read data: fresh random Q every cycle, remembered by cycle.
   initial begin
      forever begin
         @(negedge PCLK);
         q0 = half_t'($urandom());
         q1 = half_t'($urandom());
         q_hist[cyc] = {q1, q0};
      end
   end

   // Present one command, then compare every cycle of its burst.
   task automatic run_cmd(input bit wr, input logic [3:0] len,
                          input int ur, input word_t beats [16],
                          output int acc, output int done);
      int a, t, b, e, s, fin, c;
      bit rdy_x, rv_x, last_x, oen_low;
      word_t d_x;
      a = -1;
      done = cyc;
      bus.cmd_valid_i = 1'b1;
      bus.cmd_write_i = wr;
      bus.cmd_len_i   = len;
      for (int n = 0; n < 40 && a < 0; n++) begin
         #1;
         rdy_x = !(!wr && cyc < turn_free);
         vectors++;
         if (bus.cmd_ready_o !== rdy_x) begin
            miscompares++;
            $display("FAIL cmd_ready cyc=%0d got=%b exp=%b",
                     cyc, bus.cmd_ready_o, rdy_x);
         end
         if (bus.cmd_ready_o === 1'b1) begin
            a = cyc;
         end else begin
            @(negedge PCLK);
            bus.wr_valid_i = 1'($urandom());
            bus.wr_data_i  = word_t'($urandom());
            vectors++;
            if (oen !== '1 || bus.wr_ready_o !== 1'b0 ||
                bus.rd_valid_o !== 1'b0) begin
               miscompares++;
               $display("FAIL idle_pins cyc=%0d oen=%h rdy=%b rv=%b exp=ffff/0/0",
                        cyc, oen, bus.wr_ready_o, bus.rd_valid_o);
            end
         end
      end
      acc = a;
      if (a < 0) begin
         miscompares++;
         $display("FAIL accept_timeout cyc=%0d got=none exp=accept", cyc);
         bus.cmd_valid_i = 1'b0;
         return;
      end
      t = a + WR_LAT + 1;
      b = t + PRE;
      e = b + int'(len);
      s = a + RD_LAT;
      fin = wr ? e + POST + 1 : s + int'(len) + 1;
      c = a;
      while (c < fin) begin
         @(negedge PCLK);
         c = cyc;
         if (wr) begin
            oen_low = (c >= t && c <= e + POST);
            d_x = (c >= b && c <= e && (c - b) != ur) ? beats[c - b] : '0;
            rdy_x = (c >= b - 1 && c <= e - 1);
            rv_x = 1'b0;
            last_x = 1'b0;
            if (ur >= 0 && ur <= int'(len) && c >= b + ur) err_exp = 1'b1;
         end else begin
            oen_low = 1'b0;
            d_x = '0;
            rdy_x = 1'b0;
            rv_x = (c >= s + 1 && c <= fin);
            last_x = (c == fin);
         end
         vectors += 6;
         if (oen !== (oen_low ? '0 : '1)) begin
            miscompares++;
            $display("FAIL oen cyc=%0d got=%h exp_low=%b", c, oen, oen_low);
         end
         if ({d1, d0} !== d_x) begin
            miscompares++;
            $display("FAIL dq cyc=%0d got=%h exp=%h", c, {d1, d0}, d_x);
         end
         if (bus.wr_ready_o !== rdy_x) begin
            miscompares++;
            $display("FAIL wr_ready cyc=%0d got=%b exp=%b",
                     c, bus.wr_ready_o, rdy_x);
         end
         if (bus.rd_valid_o !== rv_x) begin
            miscompares++;
            $display("FAIL rd_valid cyc=%0d got=%b exp=%b",
                     c, bus.rd_valid_o, rv_x);
         end
         if (bus.rd_last_o !== last_x) begin
            miscompares++;
            $display("FAIL rd_last cyc=%0d got=%b exp=%b",
                     c, bus.rd_last_o, last_x);
         end
         if (bus.err_underrun_o !== err_exp) begin
            miscompares++;
            $display("FAIL err_underrun cyc=%0d got=%b exp=%b",
                     c, bus.err_underrun_o, err_exp);
         end
         if (rv_x) begin
            vectors++;
            if (bus.rd_data_o !== q_hist[c - 1]) begin
               miscompares++;
               $display("FAIL rd_data cyc=%0d got=%h exp=%h",
                        c, bus.rd_data_o, q_hist[c - 1]);
            end
         end
         if (c < fin) begin
            vectors++;
            if (bus.cmd_ready_o !== 1'b0) begin
               miscompares++;
               $display("FAIL busy_ready cyc=%0d got=%b exp=0",
                        c, bus.cmd_ready_o);
            end
         end
         if (wr && c >= b - 1 && c <= e - 1) begin
            bus.wr_valid_i = ((c - b + 1) != ur);
            bus.wr_data_i  = bus.wr_valid_i ? beats[c - b + 1]
                                            : word_t'($urandom());
         end else begin
            bus.wr_valid_i = 1'($urandom());
            bus.wr_data_i  = word_t'($urandom());
         end
         if (c < fin) begin
            bus.cmd_valid_i = 1'($urandom());
            bus.cmd_write_i = 1'($urandom());
            bus.cmd_len_i   = 4'($urandom());
         end else begin
            bus.cmd_valid_i = 1'b0;
         end
      end
      if (wr) turn_free = fin + TURN;
      done = fin;
   endtask

   task automatic rand_beats(output word_t beats [16]);
      for (int i = 0; i < 16; i++) beats[i] = word_t'($urandom());
   endtask

   task automatic test_reset();
      bus.cmd_valid_i = 1'b1;
      bus.cmd_write_i = 1'b1;
      @(negedge PCLK);
      vectors += 3;
      if (bus.cmd_ready_o !== 1'b0 || bus.wr_ready_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready got=%b/%b exp=0/0",
                  bus.cmd_ready_o, bus.wr_ready_o);
      end
      if (oen !== '1 || d0 !== '0 || d1 !== '0) begin
         miscompares++;
         $display("FAIL reset_pins got=%h/%h/%h exp=ffff/0/0", oen, d0, d1);
      end
      if (bus.rd_valid_o !== 1'b0 || bus.rd_last_o !== 1'b0 ||
          bus.rd_data_o !== '0 || bus.err_underrun_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_rd got=%b/%b/%h/%b exp=0/0/0/0", bus.rd_valid_o,
                  bus.rd_last_o, bus.rd_data_o, bus.err_underrun_o);
      end
      bus.cmd_valid_i = 1'b0;
      RESET = 1'b0;
      #1;
      vectors++;
      if (bus.cmd_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset_ready got=%b exp=1", bus.cmd_ready_o);
      end
   endtask

   task automatic test_write();
      word_t bt [16];
      int acc, done;
      rand_beats(bt);
      bt[0] = 32'h0001_0002;
      bt[1] = 32'h0003_0004;
      bt[2] = 32'h0005_0006;
      bt[3] = 32'h0007_0008;
      run_cmd(1'b1, 4'd3, -1, bt, acc, done);
      vectors++;
      if (done - acc !== WR_LAT + 1 + PRE + 4 + POST) begin
         miscompares++;
         $display("FAIL write_span got=%0d exp=%0d", done - acc,
                  WR_LAT + 1 + PRE + 4 + POST);
      end
   endtask

   task automatic test_read();
      word_t bt [16];
      int acc, done;
      rand_beats(bt);
      run_cmd(1'b0, 4'd1, -1, bt, acc, done);
      run_cmd(1'b0, 4'd15, -1, bt, acc, done);
   endtask

   task automatic test_turn();
      word_t bt [16];
      int acc, done;
      rand_beats(bt);
      run_cmd(1'b1, 4'd2, -1, bt, acc, done);
      run_cmd(1'b0, 4'd0, -1, bt, acc, done);
      vectors++;
      if (acc !== 0 && acc - (turn_free - TURN) !== TURN) begin
         miscompares++;
         $display("FAIL turn_gap got=%0d exp=%0d",
                  acc - (turn_free - TURN), TURN);
      end
      run_cmd(1'b1, 4'd1, -1, bt, acc, done);
      run_cmd(1'b1, 4'd0, -1, bt, acc, done);
      vectors++;
      if (acc !== turn_free - TURN - (WR_LAT + 2 + PRE + POST)) begin
         miscompares++;
         $display("FAIL write_no_turn got=%0d exp=%0d", acc,
                  turn_free - TURN - (WR_LAT + 2 + PRE + POST));
      end
   endtask

   task automatic test_back_to_back();
      word_t bt [16];
      int acc, done;
      rand_beats(bt);
      run_cmd(1'b0, 4'd2, -1, bt, acc, done);
      run_cmd(1'b0, 4'd3, -1, bt, acc, done);
      vectors++;
      if (done - acc !== RD_LAT + 4) begin
         miscompares++;
         $display("FAIL b2b_read_span got=%0d exp=%0d", done - acc, RD_LAT + 4);
      end
   endtask

   task automatic test_underrun();
      word_t bt [16];
      int acc, done;
      rand_beats(bt);
      run_cmd(1'b1, 4'd3, 2, bt, acc, done);
      run_cmd(1'b1, 4'd1, -1, bt, acc, done);
      run_cmd(1'b0, 4'd1, -1, bt, acc, done);
      vectors++;
      if (bus.err_underrun_o !== 1'b1) begin
         miscompares++;
         $display("FAIL underrun_sticky got=%b exp=1", bus.err_underrun_o);
      end
   endtask

   task automatic test_reset_mid();
      word_t bt [16];
      int a, b, acc, done;
      rand_beats(bt);
      a = -1;
      bus.cmd_valid_i = 1'b1;
      bus.cmd_write_i = 1'b1;
      bus.cmd_len_i   = 4'd3;
      for (int n = 0; n < 40 && a < 0; n++) begin
         #1;
         if (bus.cmd_ready_o === 1'b1) a = cyc;
         else @(negedge PCLK);
      end
      vectors++;
      if (a < 0) begin
         miscompares++;
         $display("FAIL mid_accept got=none exp=accept");
         $fatal(1, "no accept");
      end
      b = a + WR_LAT + 1 + PRE;
      for (int n = 0; n < 40; n++) begin
         @(negedge PCLK);
         bus.cmd_valid_i = 1'b0;
         if (cyc >= b + 1) break;
         bus.wr_valid_i = 1'b1;
         bus.wr_data_i  = (cyc >= b - 1) ? bt[cyc - b + 1] : '0;
      end
      vectors++;
      if ({d1, d0} !== bt[1] || oen !== '0) begin
         miscompares++;
         $display("FAIL mid_beat1 got=%h/%h exp=%h/0000", {d1, d0}, oen, bt[1]);
      end
      #1 RESET = 1'b1;
      #1;
      vectors++;
      if (oen !== '1 || d0 !== '0 || d1 !== '0 || bus.wr_ready_o !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_pins got=%h/%h/%h/%b exp=ffff/0/0/0",
                  oen, d0, d1, bus.wr_ready_o);
      end
      for (int n = 0; n < 2; n++) begin
         @(negedge PCLK);
         vectors++;
         if (bus.wr_ready_o !== 1'b0 || oen !== '1) begin
            miscompares++;
            $display("FAIL mid_reset_hold got=%b/%h exp=0/ffff",
                     bus.wr_ready_o, oen);
         end
      end
      RESET = 1'b0;
      err_exp = 1'b0;
      turn_free = 0;
      #1;
      vectors++;
      if (bus.cmd_ready_o !== 1'b1 || bus.err_underrun_o !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_release got=%b/%b exp=1/0",
                  bus.cmd_ready_o, bus.err_underrun_o);
      end
      run_cmd(1'b1, 4'd2, -1, bt, acc, done);
   endtask

   task automatic test_random();
      word_t bt [16];
      int acc, done, ur;
      logic [3:0] len;
      bit wr;
      for (int i = 0; i < 24; i++) begin
         rand_beats(bt);
         wr  = 1'($urandom());
         len = 4'($urandom());
         ur  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(len)) : -1;
         run_cmd(wr, len, ur, bt, acc, done);
      end
   endtask

   task automatic test_zero_phase();
      int a, t, lows;
      word_t beat, d_x;
      bit rv_x;
      beat = word_t'($urandom());
      a = -1;
      lows = 0;
      bus2.cmd_valid_i = 1'b1;
      bus2.cmd_write_i = 1'b1;
      bus2.cmd_len_i   = 4'd0;
      for (int n = 0; n < 20 && a < 0; n++) begin
         #1;
         if (bus2.cmd_ready_o === 1'b1) a = cyc;
         else @(negedge PCLK);
      end
      vectors++;
      if (a < 0) begin
         miscompares++;
         $display("FAIL z_accept got=none exp=accept");
         $fatal(1, "no accept");
      end
      t = a + Z_WR_LAT + 1;
      for (int c = a + 1; c <= t + 2; c++) begin
         @(negedge PCLK);
         if (z_oen === '0) lows++;
         d_x = (cyc == t) ? beat : '0;
         vectors += 2;
         if (z_oen !== ((cyc == t) ? '0 : '1) || {z_d1, z_d0} !== d_x) begin
            miscompares++;
            $display("FAIL z_write cyc=%0d got=%h/%h exp_beat=%h",
                     cyc, z_oen, {z_d1, z_d0}, d_x);
         end
         if (bus2.wr_ready_o !== (cyc == t - 1)) begin
            miscompares++;
            $display("FAIL z_wr_ready cyc=%0d got=%b exp=%b",
                     cyc, bus2.wr_ready_o, cyc == t - 1);
         end
         bus2.cmd_valid_i = 1'b0;
         bus2.wr_valid_i  = (cyc == t - 1);
         bus2.wr_data_i   = beat;
      end
      vectors++;
      if (lows !== 1) begin
         miscompares++;
         $display("FAIL z_oen_cycles got=%0d exp=1", lows);
      end
      bus2.cmd_valid_i = 1'b1;
      bus2.cmd_write_i = 1'b0;
      bus2.cmd_len_i   = 4'd2;
      #1;
      a = cyc;
      vectors++;
      if (bus2.cmd_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL z_read_ready got=%b exp=1", bus2.cmd_ready_o);
      end
      for (int c = a + 1; c <= a + 5; c++) begin
         @(negedge PCLK);
         bus2.cmd_valid_i = 1'b0;
         rv_x = (cyc >= a + 2 && cyc <= a + 4);
         vectors += 2;
         if (bus2.rd_valid_o !== rv_x ||
             bus2.rd_last_o !== (cyc == a + 4)) begin
            miscompares++;
            $display("FAIL z_read_flags cyc=%0d got=%b/%b exp=%b/%b", cyc,
                     bus2.rd_valid_o, bus2.rd_last_o, rv_x, cyc == a + 4);
         end
         if (rv_x && bus2.rd_data_o !== q_hist[cyc - 1]) begin
            miscompares++;
            $display("FAIL z_read_data cyc=%0d got=%h exp=%h",
                     cyc, bus2.rd_data_o, q_hist[cyc - 1]);
         end
      end
   endtask

   initial begin
      bus.cmd_valid_i  = 1'b0;
      bus.cmd_write_i  = 1'b0;
      bus.cmd_len_i    = 4'd0;
      bus.wr_valid_i   = 1'b0;
      bus.wr_data_i    = '0;
      bus2.cmd_valid_i = 1'b0;
      bus2.cmd_write_i = 1'b0;
      bus2.cmd_len_i   = 4'd0;
      bus2.wr_valid_i  = 1'b0;
      bus2.wr_data_i   = '0;
      repeat (3) @(negedge PCLK);
      test_reset();
      test_write();
      test_read();
      test_turn();
      test_back_to_back();
      test_underrun();
      test_reset_mid();
      test_random();
      test_zero_phase();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
